// File: rtl/mul_sequencer.sv
// Shift-and-add 64-bit MUL (low product) sequencer that borrows the execute-stage ALU adder.
// Optional macro MUL_EARLY_TERM_EN: finish as soon as the remaining multiplier bits are all zero.
module mul_sequencer #(
    parameter int WIDTH = 64,
    parameter int CNT_W = 7
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [WIDTH-1:0] mul_a,
    input  logic [WIDTH-1:0] mul_b,
    input  logic [WIDTH-1:0] ex_data_1,
    input  logic [WIDTH-1:0] ex_data_2,
    input  logic [3:0]       ex_control,
    input  logic [WIDTH-1:0] alu_result,
    output logic [WIDTH-1:0] alu_data_1,
    output logic [WIDTH-1:0] alu_data_2,
    output logic [3:0]       alu_control,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] product
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [3:0]       ALU_ADD  = 4'b0010;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

`ifdef MUL_EARLY_TERM_EN
    localparam bit EARLY_TERM = 1'b1;
`else
    localparam bit EARLY_TERM = 1'b0;
`endif

    state_t           state_q,   state_d;
    logic [WIDTH-1:0] mcand_q,   mcand_d;
    logic [WIDTH-1:0] mplier_q,  mplier_d;
    logic [WIDTH-1:0] acc_q,     acc_d;
    logic [WIDTH-1:0] product_q, product_d;
    logic [CNT_W-1:0] count_q,   count_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            mcand_q   <= '0;
            mplier_q  <= '0;
            acc_q     <= '0;
            product_q <= '0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            acc_q     <= acc_d;
            product_q <= product_d;
            count_q   <= count_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        mcand_d     = mcand_q;
        mplier_d    = mplier_q;
        acc_d       = acc_q;
        product_d   = product_q;
        count_d     = count_q;
        alu_data_1  = ex_data_1;
        alu_data_2  = ex_data_2;
        alu_control = ex_control;
        busy        = 1'b0;
        done        = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    mcand_d  = mul_a;
                    mplier_d = mul_b;
                    acc_d    = '0;
                    count_d  = '0;
                    state_d  = RUN;
                end
            end
            RUN: begin
                busy        = 1'b1;
                alu_data_1  = acc_q;
                alu_data_2  = mcand_q;
                alu_control = ALU_ADD;
                if (EARLY_TERM && (mplier_q == '0)) begin
                    // Nothing left to add: the accumulator already holds the product.
                    product_d = acc_q;
                    state_d   = DONE;
                end else begin
                    if (mplier_q[0]) begin
                        acc_d = alu_result;
                    end
                    mcand_d  = mcand_q << 1;
                    mplier_d = mplier_q >> 1;
                    count_d  = count_q + 1'b1;
                    if (count_q == LAST_CNT) begin
                        product_d = acc_d;
                        state_d   = DONE;
                    end
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign product = product_q;

endmodule

// File: tb/tb_mul_sequencer.sv
// Scoreboard bench for mul_sequencer: driver queues expected product/timing, monitor checks on done.
module tb_mul_sequencer;

    localparam int W = 64;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         start;
    logic [W-1:0] mul_a, mul_b;
    logic [W-1:0] ex_data_1, ex_data_2;
    logic [3:0]   ex_control;
    logic [W-1:0] alu_result;
    logic [W-1:0] alu_data_1, alu_data_2;
    logic [3:0]   alu_control;
    logic         busy, done;
    logic [W-1:0] product;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    typedef struct {
        logic [W-1:0] prod;
        int           done_cyc;
        int           lat;
    } exp_t;

    exp_t sb[$];

    mul_sequencer #(.WIDTH(W), .CNT_W(7)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .start       (start),
        .mul_a       (mul_a),
        .mul_b       (mul_b),
        .ex_data_1   (ex_data_1),
        .ex_data_2   (ex_data_2),
        .ex_control  (ex_control),
        .alu_result  (alu_result),
        .alu_data_1  (alu_data_1),
        .alu_data_2  (alu_data_2),
        .alu_control (alu_control),
        .busy        (busy),
        .done        (done),
        .product     (product)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // Simple ALU model sitting behind the sequencer.
    always_comb begin
        case (alu_control)
            4'b0000: alu_result = alu_data_1 & alu_data_2;
            4'b0001: alu_result = alu_data_1 | alu_data_2;
            4'b0010: alu_result = alu_data_1 + alu_data_2;
            4'b0110: alu_result = alu_data_1 - alu_data_2;
            default: alu_result = '0;
        endcase
    end

    task automatic chk(string name, logic [W-1:0] act, logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int exp_lat(logic [W-1:0] b);
`ifdef MUL_EARLY_TERM_EN
        int msb = -1;
        for (int i = 0; i < W; i++) if (b[i]) msb = i;
        return (msb + 2 > W) ? W : msb + 2;
`else
        return (b === b) ? W : W;
`endif
    endfunction

    // Monitor: every done pulse must match the oldest queued expectation.
    int busy_run = 0;
    always @(negedge clk) begin
        if (!reset_n) begin
            busy_run = 0;
        end else begin
            if (busy) busy_run++;
            if (done) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: got done=1 expected none, product=%h (cycle %0d)", product, cyc);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("product", product, e.prod);
                    chk("done_cycle", W'(cyc), W'(e.done_cyc));
                    chk("busy_cycles", W'(busy_run), W'(e.lat));
                    chk("busy_in_done", W'(busy), '0);
                end
                busy_run = 0;
            end
        end
    end

    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] p);
        exp_t e;
        @(negedge clk);
        start = 1'b1;
        mul_a = a;
        mul_b = b;
        @(posedge clk);
        #1;
        e.prod     = p;
        e.lat      = exp_lat(b);
        e.done_cyc = cyc + e.lat;
        sb.push_back(e);
        start = 1'b0;
        mul_a = 64'hA5A5_5A5A_DEAD_BEEF;
        mul_b = 64'h1234_5678_9ABC_DEF0;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 200 && sb.size() != 0; i++) begin
            @(negedge clk);
            #2;
        end
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: got no done expected %0d pending (cycle %0d)", sb.size(), cyc);
            sb.delete();
        end
        @(posedge clk);
        #1;
    endtask

    task automatic chk_pass(string tag);
        chk({tag, "_d1"}, alu_data_1, ex_data_1);
        chk({tag, "_d2"}, alu_data_2, ex_data_2);
        chk({tag, "_ctl"}, W'(alu_control), W'(ex_control));
        chk({tag, "_busy"}, W'(busy), '0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish (cycle %0d)", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        reset_n    = 1'b0;
        start      = 1'b0;
        mul_a      = '0;
        mul_b      = '0;
        ex_data_1  = 64'd15;
        ex_data_2  = 64'd10;
        ex_control = 4'b0110;
        #1;
        chk("rst_done", W'(done), '0);
        chk("rst_product", product, '0);
        chk_pass("rst_pass");
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;

        // Pass-through in IDLE, same cycle
        @(negedge clk);
        ex_data_1  = 64'd33;
        ex_data_2  = 64'd44;
        ex_control = 4'b0001;
        #1;
        chk_pass("idle_pass");
        ex_data_1  = 64'd15;
        ex_data_2  = 64'd10;
        ex_control = 4'b0110;
        #1;
        chk_pass("idle_pass2");

        // Basic multiply; first RUN cycle owns the ALU
        issue(64'd15, 64'd10, 64'd150);
        chk("run_d1", alu_data_1, '0);
        chk("run_d2", alu_data_2, 64'd15);
        chk("run_ctl", W'(alu_control), W'(4'b0010));
        chk("run_busy", W'(busy), 64'd1);
        wait_done();
        chk_pass("after_mul");

        // Wrap and sign
        issue(64'h8000_0000_0000_0000, 64'd2, 64'd0);
        wait_done();
        issue(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1);
        wait_done();
        issue(64'hFFFF_FFFF_FFFF_FFFF, 64'd7, 64'hFFFF_FFFF_FFFF_FFF9);
        wait_done();

        // start re-pulsed while running is ignored
        issue(64'd15, 64'd15, 64'd225);
`ifdef MUL_EARLY_TERM_EN
        repeat (1) @(posedge clk);
`else
        repeat (9) @(posedge clk);
`endif
        @(negedge clk);
        start = 1'b1;
        mul_a = 64'd3;
        mul_b = 64'd3;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done();
        repeat (80) @(negedge clk);
        chk("ignored_product_held", product, 64'd225);

        // Reset mid-operation aborts without a done pulse
        issue(64'd9, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0);
        repeat (19) @(posedge clk);
        #1;
        reset_n = 1'b0;
        sb.delete();
        #1;
        chk("abort_done", W'(done), '0);
        chk("abort_product", product, '0);
        chk_pass("abort_pass");
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (70) @(negedge clk);
        issue(64'd6, 64'd7, 64'd42);
        wait_done();

        // Operands that terminate early when that option is built in
        issue(64'd15, 64'd2, 64'd30);
        wait_done();
        issue(64'd15, 64'd0, 64'd0);
        wait_done();

        repeat (5) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
